// File: rtl/alu_md.sv
// Integer ALU with iterative multiply/divide: single-cycle ops finish in one cycle,
// MUL/DIV ops take XLEN cycles (shift-add multiply, restoring divide) before DONE.
module alu_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic            use_imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0]        opb;
  logic signed [XLEN-1:0] rs1_s, opb_s;
  logic                   accept, is_md, last;
  logic [XLEN-1:0]        alu_res;

  logic [XLEN-1:0]   acc, lo, opnd, a_r;
  logic [SHW-1:0]    cnt;
  logic [4:0]        op_r;
  logic              neg_q, neg_r, b_zero;

  logic [XLEN-1:0]   step_acc, step_lo, fin;
  logic [XLEN:0]     sum, sh, diff;
  logic [2*XLEN-1:0] prod, prod_s;

  logic            sa, sb, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;

  function automatic logic [XLEN-1:0] cneg(input logic n, input logic [XLEN-1:0] v);
    cneg = n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_wide(input logic n, input logic [2*XLEN-1:0] v);
    cneg_wide = n ? -v : v;
  endfunction

  assign opb       = use_imm ? imm : rs2;
  assign rs1_s     = rs1;
  assign opb_s     = opb;
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_md     = (op >= 5'd12) && (op <= 5'd19);
  assign last      = (cnt == SHW'(XLEN - 1));

  // Operand sign handling: the iterative core works on magnitudes only
  assign sa    = (op == 5'd13) || (op == 5'd14) || (op == 5'd16) || (op == 5'd18);
  assign sb    = (op == 5'd13) || (op == 5'd16) || (op == 5'd18);
  assign a_neg = sa && rs1[XLEN-1];
  assign b_neg = sb && opb[XLEN-1];
  assign a_abs = cneg(a_neg, rs1);
  assign b_abs = cneg(b_neg, opb);

  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:    alu_res = rs1 + opb;
      5'd1:    alu_res = rs1 - opb;
      5'd2:    alu_res = rs1 ^ opb;
      5'd3:    alu_res = rs1 | opb;
      5'd4:    alu_res = rs1 & opb;
      5'd5:    alu_res = rs1 << opb[SHW-1:0];
      5'd6:    alu_res = rs1 >> opb[SHW-1:0];
      5'd7:    alu_res = rs1_s >>> opb[SHW-1:0];
      5'd8:    alu_res = XLEN'(rs1_s < opb_s);
      5'd9:    alu_res = XLEN'(rs1 < opb);
      5'd10:   alu_res = opb;
      5'd11:   alu_res = pc + opb;
      default: alu_res = '0;
    endcase
  end

  // One iteration: divide shifts the dividend into acc, multiply shifts the product right
  always_comb begin
    sum      = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    sh       = {acc, lo[XLEN-1]};
    diff     = sh - {1'b0, opnd};
    step_acc = '0;
    step_lo  = '0;
    if (op_r[4]) begin
      if (!diff[XLEN]) begin
        step_acc = diff[XLEN-1:0];
        step_lo  = {lo[XLEN-2:0], 1'b1};
      end else begin
        step_acc = sh[XLEN-1:0];
        step_lo  = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      step_acc = sum[XLEN:1];
      step_lo  = {sum[0], lo[XLEN-1:1]};
    end
    prod   = {step_acc, step_lo};
    prod_s = cneg_wide(neg_q, prod);
    fin    = '0;
    if (op_r == 5'd12)
      fin = prod_s[XLEN-1:0];
    else if (!op_r[4])
      fin = prod_s[2*XLEN-1:XLEN];
    else if (!op_r[1])
      fin = b_zero ? '1 : cneg(neg_q, step_lo);
    else
      fin = b_zero ? a_r : cneg(neg_r, step_acc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_md ? CALC : DONE;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      a_r    <= '0;
      cnt    <= '0;
      op_r   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        op_r <= op;
        if (is_md) begin
          acc    <= '0;
          lo     <= a_abs;
          opnd   <= b_abs;
          a_r    <= rs1;
          cnt    <= '0;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          b_zero <= (opb == '0);
        end else begin
          result <= alu_res;
        end
      end
      if (state == CALC) begin
        acc <= step_acc;
        lo  <= step_lo;
        cnt <= cnt + 1'b1;
        if (last) result <= fin;
      end
    end
  end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  5  operation code per REQ-014.
REQ-008 use_imm  input  1  1: operand B = imm; 0: operand B = rs2.
REQ-009 rs1, rs2, imm, pc  input  XLEN each  operands; imm is already sign-extended to XLEN.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  XLEN  registered result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Op codes: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 LUI, 11 AUIPC, 12 MUL, 13 MULH, 14 MULHSU, 15 MULHU, 16 DIV, 17 DIVU, 18 REM, 19 REMU; codes 20-31 produce result 0 with single-cycle latency.
REQ-015 Shifts use B[SHW-1:0] only; SRA is arithmetic (sign fill from rs1[XLEN-1]).
REQ-016 SLT compares two's-complement signed; SLTU unsigned; result is 0 or 1, zero-extended.
REQ-017 LUI result = B; AUIPC result = pc + B; the caller pre-shifts imm.
REQ-018 All add/sub wrap modulo 2^XLEN; no flags are produced.
REQ-019 FSM states: IDLE, CALC, DONE; reset state IDLE.
REQ-020 Handshake: a request is accepted when in_valid && in_ready; in_ready = 1 only in IDLE.
REQ-021 Single-cycle ops: IDLE -> DONE on accept; out_valid rises the cycle after accept.
REQ-022 MUL/DIV ops: IDLE -> CALC on accept; CALC lasts exactly XLEN cycles (one bit per cycle, shift-add multiply, restoring divide); then -> DONE, so out_valid rises XLEN+1 cycles after accept.
REQ-023 MUL returns the low XLEN bits of the product; MULH/MULHSU/MULHU return the high XLEN bits with signed x signed, signed x unsigned, and unsigned x unsigned operands respectively.
REQ-024 Divide by zero: DIV/DIVU result all-ones; REM/REMU result = rs1. Latency stays XLEN+1.
REQ-025 Signed overflow (rs1 = most-negative, B = -1): DIV result = rs1; REM result = 0.
REQ-026 Signed DIV/REM: quotient is truncated toward zero; remainder takes the sign of the dividend.
REQ-027 DONE: result and out_valid stay stable until out_ready = 1; on that edge the FSM goes to IDLE and out_valid drops. No back-to-back acceptance from DONE.
REQ-028 in_valid in CALC or DONE is ignored; operands are captured only on accept, so later changes to the input ports have no effect.
REQ-029 out_ready while not in DONE has no effect.

Reset
REQ-030 rst_n = 0 at a rising edge forces: state IDLE, out_valid 0, result 0, busy 0, in_ready 1 from the next cycle.
REQ-031 Reset mid-CALC or in DONE aborts the operation and discards the result; no out_valid is produced for it.
REQ-032 All internal counters and accumulators are cleared by reset.

Verification
REQ-033 ADD, XLEN=32: rs1=0xFFFFFFFF, rs2=1, use_imm=0 -> out_valid one cycle after accept, result 0x00000000.
REQ-034 SRA vs SRL: rs1=0x80000000, imm=4, use_imm=1 -> SRA gives 0xF8000000; SRL gives 0x08000000; SLT(-1,1) gives 1; SLTU(-1,1) gives 0.
REQ-035 MULH -2 x 3 -> result 0xFFFFFFFF after exactly 33 cycles; MUL gives 0xFFFFFFFA; busy high and in_ready low throughout.
REQ-036 DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; REM -7/2 -> 0xFFFFFFFF (-1).
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_valid ignored; out_ready=1 -> IDLE next cycle, next request accepted.
REQ-038 rst_n=0 at cycle 10 of a DIV -> out_valid stays 0, state IDLE; a subsequent ADD completes normally.
